// File: rtl/zx_fdd_pkg.sv
// Shared constants for the ZX Spectrum <-> Timex FDD mailbox: status bit
// positions, default geometry and the strobe index map used by the top level.
package zx_fdd_pkg;
  localparam int ST_RXAVAIL = 0;
  localparam int ST_TXSPACE = 1;
  localparam int ST_OVF     = 2;
  localparam int ST_UDF     = 3;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_DEPTH = 4;

  localparam int NSTB      = 6;
  localparam int STB_ZX_WR = 0;
  localparam int STB_ZX_RD = 1;
  localparam int STB_ZX_ST = 2;
  localparam int STB_FD_WR = 3;
  localparam int STB_FD_RD = 4;
  localparam int STB_FD_ST = 5;
  // Write strobes act on their falling edge, reads and status reads on their rising edge.
  localparam logic [NSTB-1:0] STB_WR_MASK = 6'b001001;
endpackage

// File: rtl/zx_fdd_fifo.sv
// Single-clock FIFO for one mailbox direction. Overflow/underflow are one-cycle
// pulses; head holds the last popped word while the FIFO is empty.
module zx_fdd_fifo
  import zx_fdd_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head,
  output logic             ovf,
  output logic             udf
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      cnt;
  logic [WIDTH-1:0] last_pop;
  logic             push_ok;
  logic             pop_ok;

  assign empty   = (cnt == '0);
  assign full    = (cnt == (AW+1)'(DEPTH));
  // A pop in the same cycle frees the slot, so a push at full still lands.
  assign pop_ok  = pop & ~empty;
  assign push_ok = push & (~full | pop_ok);
  assign ovf     = push & ~push_ok;
  assign udf     = pop & empty;
  assign head    = empty ? last_pop : mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      cnt      <= '0;
      last_pop <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok) begin
        rd_ptr   <= rd_ptr + 1'b1;
        last_pop <= mem[rd_ptr];
      end
      cnt <= cnt + {{AW{1'b0}}, push_ok} - {{AW{1'b0}}, pop_ok};
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= din;
  end
endmodule

// File: rtl/zx_fdd_mailbox.sv
// Bidirectional ZX <-> FDD mailbox: synchronised bus strobes drive two FIFOs,
// each side reads its receive FIFO head or a status word with sticky errors.
module zx_fdd_mailbox
  import zx_fdd_pkg::*;
#(
  parameter int WIDTH       = DEF_WIDTH,
  parameter int DEPTH       = DEF_DEPTH,
  parameter int SYNC_STAGES = 2,
  parameter int DRQ_BIT     = 7
) (
  input  logic             CLK_16MHZ,
  input  logic             RESET,
  input  logic             nZX_DATA_WR,
  input  logic             nZX_DATA_RD,
  input  logic             nZX_STAT_RD,
  input  logic [WIDTH-1:0] ZX_DIN,
  output logic [WIDTH-1:0] ZX_DOUT,
  output logic             ZX_DOE,
  input  logic             nTIOUT,
  input  logic             nTIIN,
  input  logic             nTISTAT,
  input  logic [WIDTH-1:0] FDD_DIN,
  output logic [WIDTH-1:0] FDD_DOUT,
  output logic             FDD_DOE,
  input  logic             WD1770_DRQ
);
  logic [NSTB-1:0]        stb_raw;
  logic [NSTB-1:0]        stb_evt;
  logic [SYNC_STAGES-1:0] drq_chain;
  logic [WIDTH-1:0]       zx_din_q, fdd_din_q;
  logic                   zx_ovf, zx_udf, fdd_ovf, fdd_udf;
  logic                   zx_clr, fdd_clr;
  logic                   a2f_full, a2f_empty, a2f_ovf, a2f_udf;
  logic                   f2a_full, f2a_empty, f2a_ovf, f2a_udf;
  logic [WIDTH-1:0]       a2f_head, f2a_head;
  logic [WIDTH-1:0]       zx_stat, fdd_stat;

  assign stb_raw = {nTISTAT, nTIIN, nTIOUT, nZX_STAT_RD, nZX_DATA_RD, nZX_DATA_WR};

  // 'live' marks when the chain output is a real post-reset sample; a strobe is
  // armed only once seen inactive, so a strobe held across reset yields no event.
  for (genvar g = 0; g < NSTB; g++) begin : g_stb
    logic [SYNC_STAGES-1:0] chain;
    logic [SYNC_STAGES-1:0] live;
    logic                   prev;
    logic                   armed;

    always_ff @(posedge CLK_16MHZ or posedge RESET) begin
      if (RESET) begin
        chain <= '1;
        live  <= '0;
        prev  <= 1'b1;
        armed <= 1'b0;
      end else begin
        chain <= {chain[SYNC_STAGES-2:0], stb_raw[g]};
        live  <= {live[SYNC_STAGES-2:0], 1'b1};
        prev  <= chain[SYNC_STAGES-1];
        armed <= armed | (live[SYNC_STAGES-1] & chain[SYNC_STAGES-1]);
      end
    end

    if (STB_WR_MASK[g]) begin : g_start
      assign stb_evt[g] = armed & prev & ~chain[SYNC_STAGES-1];
    end else begin : g_end
      assign stb_evt[g] = armed & ~prev & chain[SYNC_STAGES-1];
    end
  end

  always_ff @(posedge CLK_16MHZ or posedge RESET) begin
    if (RESET) begin
      drq_chain <= '0;
      zx_din_q  <= '0;
      fdd_din_q <= '0;
      zx_ovf    <= 1'b0;
      zx_udf    <= 1'b0;
      fdd_ovf   <= 1'b0;
      fdd_udf   <= 1'b0;
    end else begin
      drq_chain <= {drq_chain[SYNC_STAGES-2:0], WD1770_DRQ};
      zx_din_q  <= ZX_DIN;
      fdd_din_q <= FDD_DIN;
      // A new error in the clearing cycle keeps its flag set.
      zx_ovf  <= a2f_ovf | (zx_ovf  & ~zx_clr);
      zx_udf  <= f2a_udf | (zx_udf  & ~zx_clr);
      fdd_ovf <= f2a_ovf | (fdd_ovf & ~fdd_clr);
      fdd_udf <= a2f_udf | (fdd_udf & ~fdd_clr);
    end
  end

  // A data read overlapping the status read suppresses the clear.
  assign zx_clr  = stb_evt[STB_ZX_ST] & ~stb_evt[STB_ZX_RD]
                   & g_stb[STB_ZX_RD].chain[SYNC_STAGES-1];
  assign fdd_clr = stb_evt[STB_FD_ST] & ~stb_evt[STB_FD_RD]
                   & g_stb[STB_FD_RD].chain[SYNC_STAGES-1];

  zx_fdd_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_a2f (
    .clk(CLK_16MHZ), .rst(RESET),
    .push(stb_evt[STB_ZX_WR]), .pop(stb_evt[STB_FD_RD]), .din(zx_din_q),
    .full(a2f_full), .empty(a2f_empty), .head(a2f_head),
    .ovf(a2f_ovf), .udf(a2f_udf)
  );

  zx_fdd_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_f2a (
    .clk(CLK_16MHZ), .rst(RESET),
    .push(stb_evt[STB_FD_WR]), .pop(stb_evt[STB_ZX_RD]), .din(fdd_din_q),
    .full(f2a_full), .empty(f2a_empty), .head(f2a_head),
    .ovf(f2a_ovf), .udf(f2a_udf)
  );

  always_comb begin
    zx_stat              = '0;
    zx_stat[ST_RXAVAIL]  = ~f2a_empty;
    zx_stat[ST_TXSPACE]  = ~a2f_full;
    zx_stat[ST_OVF]      = zx_ovf;
    zx_stat[ST_UDF]      = zx_udf;
    fdd_stat             = '0;
    fdd_stat[ST_RXAVAIL] = ~a2f_empty;
    fdd_stat[ST_TXSPACE] = ~f2a_full;
    fdd_stat[ST_OVF]     = fdd_ovf;
    fdd_stat[ST_UDF]     = fdd_udf;
    fdd_stat[DRQ_BIT]    = drq_chain[SYNC_STAGES-1];
  end

  assign ZX_DOE   = ~nZX_DATA_RD | ~nZX_STAT_RD;
  assign FDD_DOE  = ~nTIIN | ~nTISTAT;
  assign ZX_DOUT  = RESET ? '0 : ((~nZX_STAT_RD & nZX_DATA_RD) ? zx_stat : f2a_head);
  assign FDD_DOUT = RESET ? '0 : ((~nTISTAT & nTIIN) ? fdd_stat : a2f_head);
endmodule

// File: tb/tb_zx_fdd_mailbox.sv
// Bench for zx_fdd_mailbox: directed scenarios plus random bus cycles checked
// against a queue-based model of the two mailboxes and their status words.
module tb_zx_fdd_mailbox;
  localparam int W       = 8;
  localparam int DEPTH   = 4;
  localparam int DRQ_BIT = 7;
  localparam int ZX      = 0;
  localparam int FD      = 1;

  logic         clk = 1'b0;
  logic         RESET = 1'b1;
  logic         nZX_DATA_WR = 1'b1, nZX_DATA_RD = 1'b1, nZX_STAT_RD = 1'b1;
  logic         nTIOUT = 1'b1, nTIIN = 1'b1, nTISTAT = 1'b1;
  logic [W-1:0] ZX_DIN = '0, FDD_DIN = '0;
  logic [W-1:0] ZX_DOUT, FDD_DOUT;
  logic         ZX_DOE, FDD_DOE;
  logic         WD1770_DRQ = 1'b0;

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model: one queue per direction, last popped words, sticky flags.
  logic [W-1:0] a2f_exp_q[$];
  logic [W-1:0] f2a_exp_q[$];
  logic [W-1:0] zx_last, fdd_last;
  bit           zx_ovf, zx_udf, fdd_ovf, fdd_udf, drq;

  zx_fdd_mailbox #(.WIDTH(W), .DEPTH(DEPTH), .SYNC_STAGES(2), .DRQ_BIT(DRQ_BIT)) dut (
    .CLK_16MHZ(clk), .RESET(RESET),
    .nZX_DATA_WR(nZX_DATA_WR), .nZX_DATA_RD(nZX_DATA_RD), .nZX_STAT_RD(nZX_STAT_RD),
    .ZX_DIN(ZX_DIN), .ZX_DOUT(ZX_DOUT), .ZX_DOE(ZX_DOE),
    .nTIOUT(nTIOUT), .nTIIN(nTIIN), .nTISTAT(nTISTAT),
    .FDD_DIN(FDD_DIN), .FDD_DOUT(FDD_DOUT), .FDD_DOE(FDD_DOE),
    .WD1770_DRQ(WD1770_DRQ)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] exp_stat(input int side);
    logic [W-1:0] s;
    s = '0;
    if (side == ZX) begin
      s[0] = (f2a_exp_q.size() != 0);
      s[1] = (a2f_exp_q.size() < DEPTH);
      s[2] = zx_ovf;
      s[3] = zx_udf;
    end else begin
      s[0] = (a2f_exp_q.size() != 0);
      s[1] = (f2a_exp_q.size() < DEPTH);
      s[2] = fdd_ovf;
      s[3] = fdd_udf;
      s[DRQ_BIT] = drq;
    end
    return s;
  endfunction

  task automatic model_reset();
    a2f_exp_q.delete();
    f2a_exp_q.delete();
    zx_last = '0; fdd_last = '0;
    zx_ovf = 0; zx_udf = 0; fdd_ovf = 0; fdd_udf = 0;
  endtask

  task automatic model_push(input int side, input logic [W-1:0] d);
    if (side == ZX) begin
      if (a2f_exp_q.size() < DEPTH) a2f_exp_q.push_back(d); else zx_ovf = 1;
    end else begin
      if (f2a_exp_q.size() < DEPTH) f2a_exp_q.push_back(d); else fdd_ovf = 1;
    end
  endtask

  task automatic model_pop(input int side);
    if (side == ZX) begin
      if (f2a_exp_q.size() != 0) zx_last = f2a_exp_q.pop_front(); else zx_udf = 1;
    end else begin
      if (a2f_exp_q.size() != 0) fdd_last = a2f_exp_q.pop_front(); else fdd_udf = 1;
    end
  endtask

  function automatic logic [W-1:0] exp_head(input int side);
    if (side == ZX) return (f2a_exp_q.size() != 0) ? f2a_exp_q[0] : zx_last;
    return (a2f_exp_q.size() != 0) ? a2f_exp_q[0] : fdd_last;
  endfunction

  task automatic do_write(input int side, input logic [W-1:0] d);
    @(posedge clk); #1;
    if (side == ZX) begin ZX_DIN = d; nZX_DATA_WR = 1'b0; end
    else begin FDD_DIN = d; nTIOUT = 1'b0; end
    repeat (6) @(posedge clk); #1;
    if (side == ZX) nZX_DATA_WR = 1'b1; else nTIOUT = 1'b1;
    repeat (6) @(posedge clk);
    model_push(side, d);
  endtask

  task automatic do_data_read(input int side, input string tag);
    logic [W-1:0] e;
    e = exp_head(side);
    @(posedge clk); #1;
    if (side == ZX) nZX_DATA_RD = 1'b0; else nTIIN = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    check({tag, "_dout"}, (side == ZX) ? ZX_DOUT : FDD_DOUT, e);
    check({tag, "_doe"}, {7'd0, (side == ZX) ? ZX_DOE : FDD_DOE}, 8'd1);
    @(posedge clk); #1;
    if (side == ZX) nZX_DATA_RD = 1'b1; else nTIIN = 1'b1;
    repeat (6) @(posedge clk);
    model_pop(side);
  endtask

  task automatic do_stat_read(input int side, input string tag);
    logic [W-1:0] e;
    e = exp_stat(side);
    @(posedge clk); #1;
    if (side == ZX) nZX_STAT_RD = 1'b0; else nTISTAT = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    check(tag, (side == ZX) ? ZX_DOUT : FDD_DOUT, e);
    @(posedge clk); #1;
    if (side == ZX) nZX_STAT_RD = 1'b1; else nTISTAT = 1'b1;
    repeat (6) @(posedge clk);
    if (side == ZX) begin zx_ovf = 0; zx_udf = 0; end
    else begin fdd_ovf = 0; fdd_udf = 0; end
  endtask

  // FDD read end and ZX write start reach the FIFO in the same clock.
  task automatic aligned_pop_push(input logic [W-1:0] d, input string tag);
    logic [W-1:0] e;
    e = exp_head(FD);
    @(posedge clk); #1;
    ZX_DIN = d;
    nTIIN  = 1'b0;
    repeat (6) @(posedge clk);
    @(negedge clk);
    check({tag, "_dout"}, FDD_DOUT, e);
    @(posedge clk); #1;
    nTIIN       = 1'b1;
    nZX_DATA_WR = 1'b0;
    repeat (6) @(posedge clk); #1;
    nZX_DATA_WR = 1'b1;
    repeat (6) @(posedge clk);
    model_pop(FD);
    model_push(ZX, d);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    RESET = 1'b1;
    repeat (3) @(posedge clk); #1;
    RESET = 1'b0;
    model_reset();
    repeat (4) @(posedge clk);
  endtask

  task automatic set_drq(input bit v);
    @(posedge clk); #1;
    WD1770_DRQ = v;
    drq = v;
    repeat (4) @(posedge clk);
  endtask

  initial begin
    logic [W-1:0] d;
    int op;
    model_reset();
    drq = 0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_zx_dout", ZX_DOUT, 8'h00);
    check("rst_fdd_dout", FDD_DOUT, 8'h00);
    check("rst_doe", {6'd0, ZX_DOE, FDD_DOE}, 8'h00);
    @(posedge clk); #1;
    RESET = 1'b0;
    repeat (4) @(posedge clk);
    do_stat_read(ZX, "rst_zx_stat");
    do_stat_read(FD, "rst_fdd_stat");

    // ZX -> FDD transfer
    do_write(ZX, 8'hA5);
    do_write(ZX, 8'h3C);
    do_stat_read(FD, "t1_fdd_stat");
    do_data_read(FD, "t1_rd0");
    do_data_read(FD, "t1_rd1");
    do_stat_read(FD, "t1_fdd_stat_end");

    // FDD overflows F2A, flag clears on the following read
    for (int i = 0; i < 5; i++) do_write(FD, W'($urandom_range(0, 255)));
    do_stat_read(FD, "t2_fdd_ovf");
    do_stat_read(FD, "t2_fdd_clr");
    for (int i = 0; i < 4; i++) do_data_read(ZX, "t2_zx_drain");

    // Underflow from a fresh reset with A2F full
    do_reset();
    for (int i = 0; i < DEPTH; i++) do_write(ZX, W'($urandom_range(0, 255)));
    do_data_read(ZX, "t3_udf_rd");
    do_stat_read(ZX, "t3_stat_udf");
    do_stat_read(ZX, "t3_stat_clr");

    // Aligned pop/push at full, then drain and repeat at empty
    aligned_pop_push(W'($urandom_range(0, 255)), "t5_full");
    do_stat_read(ZX, "t5_zx_stat");
    for (int i = 0; i < DEPTH; i++) do_data_read(FD, "t5_drain");
    aligned_pop_push(W'($urandom_range(0, 255)), "t5_empty");
    do_stat_read(FD, "t5_fdd_stat");
    do_data_read(FD, "t5_empty_rd");

    // DRQ merged into FDD status only
    set_drq(1);
    do_stat_read(FD, "t4_drq1_fdd");
    do_stat_read(ZX, "t4_drq1_zx");
    set_drq(0);
    do_stat_read(FD, "t4_drq0_fdd");

    // Random traffic
    for (int i = 0; i < 60; i++) begin
      op = $urandom_range(0, 6);
      case (op)
        0: do_write(ZX, W'($urandom_range(0, 255)));
        1: do_write(FD, W'($urandom_range(0, 255)));
        2: do_data_read(ZX, "rnd_zx_rd");
        3: do_data_read(FD, "rnd_fdd_rd");
        4: do_stat_read(ZX, "rnd_zx_stat");
        5: do_stat_read(FD, "rnd_fdd_stat");
        default: set_drq(bit'($urandom_range(0, 1)));
      endcase
    end

    // Reset in the middle of a ZX data read with two entries queued
    do_reset();
    set_drq(0);
    do_write(FD, 8'h5A);
    do_write(FD, W'($urandom_range(0, 255)));
    @(posedge clk); #1;
    nZX_DATA_RD = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("t6_pre_dout", ZX_DOUT, 8'h5A);
    @(posedge clk); #1;
    RESET = 1'b1;
    @(negedge clk);
    check("t6_rst_dout", ZX_DOUT, 8'h00);
    check("t6_rst_doe", {7'd0, ZX_DOE}, 8'h01);
    repeat (3) @(posedge clk); #1;
    RESET = 1'b0;
    model_reset();
    repeat (8) @(posedge clk);
    @(negedge clk);
    check("t6_post_dout", ZX_DOUT, 8'h00);
    @(posedge clk); #1;
    nZX_DATA_RD = 1'b1;
    repeat (8) @(posedge clk);
    do_stat_read(ZX, "t6_zx_stat");
    do_stat_read(FD, "t6_fdd_stat");
    do_write(FD, W'($urandom_range(0, 255)));
    do_data_read(ZX, "t6_after");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
